apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB slave holding NUM_REGS read/write registers with a programmable number of wait states.
//  One instance sits on each PSEL line of the APB bus. Its PREADY/PRDATA are packed into the
//  slave arbiter's i_PREADY/i_PRDATA vectors. Register contents are also exported in parallel to core logic.
// PARAMETERS
//  DATA_WIDTH   3   width of PWDATA/PRDATA and of each register
//  ADDR_WIDTH   16  width of PADDR
//  NUM_REGS     4   number of registers (>=1); valid word addresses 0..NUM_REGS-1
//  WAIT_STATES  1   extra ACCESS cycles before PREADY (0..15)
// PORTS
//  i_PCLK     in   1                     bus clock, all state on rising edge
//  i_PRESET   in   1                     asynchronous, active-high reset
//  i_PSEL     in   1                     this slave's select bit
//  i_PENABLE  in   1                     APB access phase
//  i_PWRITE   in   1                     1 = write, 0 = read
//  i_PADDR    in   ADDR_WIDTH            word address
//  i_PWDATA   in   DATA_WIDTH            write data
//  o_PREADY   out  1                     transfer completes this cycle
//  o_PRDATA   out  DATA_WIDTH            read data, valid only when o_PREADY & read
//  o_PSLVERR  out  1                     error, valid only when o_PREADY
//  o_REGS     out  NUM_REGS*DATA_WIDTH   register r at [r*DATA_WIDTH +: DATA_WIDTH]
// BEHAVIOUR
//  Reset (async assert): state=IDLE, wait counter=0, all registers=0, latched addr/data/dir=0.
//   o_PREADY=0, o_PSLVERR=0, o_PRDATA=0, o_REGS=0. This takes effect immediately, including mid-transfer.
//  FSM states: IDLE, ACCESS.
//   IDLE: on i_PSEL & !i_PENABLE (setup cycle T0), latch PADDR, PWRITE, PWDATA.
//    Load cnt=WAIT_STATES. Go to ACCESS. All other inputs are ignored.
//   ACCESS, i_PSEL & i_PENABLE:
//    cnt!=0: cnt<=cnt-1; o_PREADY=0.
//    cnt==0: o_PREADY=1 this cycle (combinational from state and cnt). Go to IDLE next edge.
//   ACCESS, !i_PSEL: abort. Go to IDLE with no register update and no PREADY.
//   ACCESS, i_PSEL & !i_PENABLE (a new setup): treat as T0. Re-latch, reload cnt, stay in ACCESS.
//  Latency: PREADY is asserted in cycle T1+WAIT_STATES. WAIT_STATES=0 gives a zero-wait transfer at T1.
//  Error: latched addr >= NUM_REGS sets o_PSLVERR=1 together with o_PREADY. The write is suppressed
//   and o_PRDATA=0. A write or read to an address >= NUM_REGS never aliases onto an existing register.
//  Write: on the clock edge ending the PREADY cycle, reg[addr] <= latched PWDATA. o_REGS updates
//   the next cycle. Data comes from the setup-cycle latch; PWDATA changes during ACCESS are ignored.
//  Read: o_PRDATA = reg[addr] while o_PREADY & !write & !error, else 0.
//  Unselected: o_PREADY, o_PSLVERR and o_PRDATA are 0 whenever the FSM is in IDLE. The arbiter
//   compares whole PSEL/PREADY vectors, so an idle slave must never drive PREADY high.
//  Back-to-back: after the PREADY cycle the FSM is in IDLE, so the next setup can arrive in the
//   very next cycle. There are no dead cycles.
//  Reset mid-transfer: the transfer is lost and no register is written. The master must restart.
// TESTING
//  1 Reset: assert i_PRESET mid-ACCESS of a write to reg 2.
//    -> outputs 0 at once; reg2 stays 0 after release.
//  2 WAIT_STATES=1: write addr 1, data 3'h5.
//    -> PREADY only at T2, PSLVERR=0; o_REGS[5:3]=5 the following cycle.
//    Then read addr 1 -> PRDATA=5 with PREADY at T2.
//  3 WAIT_STATES=0: back-to-back write addr0=3'h7 then read addr0 with no idle cycle.
//    -> PREADY at T1 of each; read returns 7.
//  4 Error: write addr 4 (NUM_REGS=4) data 3'h3.
//    -> PREADY and PSLVERR together; o_REGS unchanged.
//    Then read addr 0xFFFF -> PSLVERR=1, PRDATA=0.
//  5 Abort: setup a write addr 3, then drop PSEL in ACCESS before cnt reaches 0.
//    -> no PREADY, reg3 unchanged, FSM in IDLE.
//  6 Idle/stability: PSEL=0 for 20 cycles with random PENABLE, PWRITE, PADDR.
//    -> PREADY, PSLVERR and PRDATA stay 0. PWDATA changed during ACCESS is not written.

Source files
------------

// File: rtl/apb_slave_regfile.sv
// APB slave register file: NUM_REGS read/write registers, programmable wait states,
// out-of-range addresses answered with PSLVERR; register contents exported on o_REGS.
module apb_slave_regfile #(
  parameter int DATA_WIDTH  = 3,
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_REGS    = 4,
  parameter int WAIT_STATES = 1
) (
  input  logic                           i_PCLK,
  input  logic                           i_PRESET,
  input  logic                           i_PSEL,
  input  logic                           i_PENABLE,
  input  logic                           i_PWRITE,
  input  logic [ADDR_WIDTH-1:0]          i_PADDR,
  input  logic [DATA_WIDTH-1:0]          i_PWDATA,
  output logic                           o_PREADY,
  output logic [DATA_WIDTH-1:0]          o_PRDATA,
  output logic                           o_PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] o_REGS
);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_t;

  localparam logic [ADDR_WIDTH:0] LP_NUM_REGS = (ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [3:0]          LP_WAIT     = 4'(WAIT_STATES);

  state_t                r_state;
  logic [3:0]            r_cnt;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_write;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  logic                  w_setup;
  logic                  w_ready;
  logic                  w_err;
  logic [DATA_WIDTH-1:0] w_rsel;

  assign w_setup = i_PSEL & ~i_PENABLE;
  // Compare one bit wider than the address so NUM_REGS never wraps.
  assign w_err   = ({1'b0, r_addr} >= LP_NUM_REGS);
  assign w_ready = (r_state == S_ACCESS) & i_PSEL & i_PENABLE & (r_cnt == '0);

  always_comb begin
    w_rsel = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      if (r_addr == ADDR_WIDTH'(r)) w_rsel = r_regs[r];
    end
  end

  assign o_PREADY  = w_ready;
  assign o_PSLVERR = w_ready & w_err;
  assign o_PRDATA  = (w_ready & ~r_write & ~w_err) ? w_rsel : '0;

  always_comb begin
    o_REGS = '0;
    for (int unsigned r = 0; r < NUM_REGS; r++) begin
      o_REGS[r*DATA_WIDTH +: DATA_WIDTH] = r_regs[r];
    end
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_addr  <= i_PADDR;
            r_write <= i_PWRITE;
            r_wdata <= i_PWDATA;
            r_cnt   <= LP_WAIT;
            r_state <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (!i_PSEL) begin
            r_state <= S_IDLE;
          end else if (!i_PENABLE) begin
            // A fresh setup while still in ACCESS restarts the transfer.
            r_addr  <= i_PADDR;
            r_write <= i_PWRITE;
            r_wdata <= i_PWDATA;
            r_cnt   <= LP_WAIT;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_PCLK or posedge i_PRESET) begin
    if (i_PRESET) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) r_regs[r] <= '0;
    end else if (w_ready & r_write & ~w_err) begin
      for (int unsigned r = 0; r < NUM_REGS; r++) begin
        if (r_addr == ADDR_WIDTH'(r)) r_regs[r] <= r_wdata;
      end
    end
  end

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: two slaves (WAIT_STATES 1 and 0) on one APB bus,
// checked every cycle against a transaction-level register model.
module tb_apb_slave_regfile;

  localparam int DW = 3;
  localparam int AW = 16;
  localparam int NR = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst;
  logic [1:0]          psel;
  logic                penable, pwrite;
  logic [AW-1:0]       paddr;
  logic [DW-1:0]       pwdata;
  logic [1:0]          rdy, err;
  logic [1:0][DW-1:0]  rd;
  logic [1:0][NR*DW-1:0] regs;

  // index 0: zero wait states, index 1: one wait state
  apb_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(0)) u_ws0 (
    .i_PCLK(clk), .i_PRESET(rst), .i_PSEL(psel[0]), .i_PENABLE(penable), .i_PWRITE(pwrite),
    .i_PADDR(paddr), .i_PWDATA(pwdata), .o_PREADY(rdy[0]), .o_PRDATA(rd[0]),
    .o_PSLVERR(err[0]), .o_REGS(regs[0]));

  apb_slave_regfile #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .WAIT_STATES(1)) u_ws1 (
    .i_PCLK(clk), .i_PRESET(rst), .i_PSEL(psel[1]), .i_PENABLE(penable), .i_PWRITE(pwrite),
    .i_PADDR(paddr), .i_PWDATA(pwdata), .o_PREADY(rdy[1]), .o_PRDATA(rd[1]),
    .o_PSLVERR(err[1]), .o_REGS(regs[1]));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0]         m_reg [2][NR];
  logic [1:0]            e_rdy, e_err;
  logic [1:0][DW-1:0]    e_rd;
  logic [1:0][NR*DW-1:0] e_regs;
  bit                    p_v;
  int                    p_d, p_a;
  logic [DW-1:0]         p_data;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] pack(input int d);
    logic [NR*DW-1:0] v;
    v = '0;
    for (int r = 0; r < NR; r++) v[r*DW +: DW] = m_reg[d][r];
    return v;
  endfunction

  task automatic clear_model();
    for (int d = 0; d < 2; d++)
      for (int r = 0; r < NR; r++) m_reg[d][r] = '0;
    p_v    = 1'b0;
    e_rdy  = '0;
    e_err  = '0;
    e_rd   = '0;
    e_regs = '0;
  endtask

  // Advance to just after the next rising edge, retire any write the model owes.
  task automatic step();
    @(posedge clk);
    #1;
    if (p_v) begin
      m_reg[p_d][p_a] = p_data;
      p_v = 1'b0;
    end
    e_rdy = '0;
    e_err = '0;
    e_rd  = '0;
    for (int d = 0; d < 2; d++) e_regs[d] = pack(d);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      step();
      psel    = '0;
      penable = 1'b0;
    end
  endtask

  // Full transfer to slave d; leaves the bench in the PREADY cycle.
  task automatic xfer(input int d, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] data);
    int ws;
    bit er;
    ws = (d == 1) ? 1 : 0;
    er = (a >= AW'(NR));
    step();
    psel    = '0;
    psel[d] = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = data;
    repeat (ws) begin
      step();
      penable = 1'b1;
      pwdata  = ~data;
    end
    step();
    penable  = 1'b1;
    pwdata   = ~data;
    e_rdy[d] = 1'b1;
    e_err[d] = er;
    if (!wr && !er) e_rd[d] = m_reg[d][a[1:0]];
    if (wr && !er) begin
      p_v    = 1'b1;
      p_d    = d;
      p_a    = int'(a[1:0]);
      p_data = data;
    end
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("cmp_pready%0d", d), 32'(rdy[d]), 32'(e_rdy[d]));
      chk($sformatf("cmp_pslverr%0d", d), 32'(err[d]), 32'(e_err[d]));
      chk($sformatf("cmp_prdata%0d", d), 32'(rd[d]), 32'(e_rd[d]));
      chk($sformatf("cmp_regs%0d", d), 32'(regs[d]), 32'(e_regs[d]));
    end
  end

  initial begin
    rst = 1'b1; psel = '0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
    clear_model();
    step();
    #2;
    chk("reset_pready", 32'(rdy), 32'h0);
    chk("reset_regs1", 32'(regs[1]), 32'h0);
    step();
    rst = 1'b0;
    idle(1);

    // one wait state: write then read address 1
    xfer(1, 1'b1, 16'd1, 3'h5);
    #2;
    chk("ws1_wr_pready", 32'(rdy[1]), 32'h1);
    chk("ws1_wr_pslverr", 32'(err[1]), 32'h0);
    idle(1);
    #2;
    chk("ws1_regs_5_3", 32'(regs[1][5:3]), 32'h5);
    xfer(1, 1'b0, 16'd1, 3'h0);
    #2;
    chk("ws1_rd_data", 32'(rd[1]), 32'h5);

    // zero wait states, back to back
    xfer(0, 1'b1, 16'd0, 3'h7);
    xfer(0, 1'b0, 16'd0, 3'h0);
    #2;
    chk("ws0_b2b_rd", 32'(rd[0]), 32'h7);
    xfer(0, 1'b1, 16'd3, 3'h2);
    xfer(0, 1'b1, 16'd1, 3'h4);
    xfer(0, 1'b0, 16'd3, 3'h0);
    xfer(1, 1'b1, 16'd0, 3'h3);
    xfer(1, 1'b1, 16'd3, 3'h6);
    idle(1);

    // out-of-range addresses
    xfer(1, 1'b1, 16'd4, 3'h3);
    #2;
    chk("err_wr_pslverr", 32'(err[1]), 32'h1);
    chk("err_wr_pready", 32'(rdy[1]), 32'h1);
    idle(1);
    xfer(1, 1'b0, 16'hFFFF, 3'h0);
    #2;
    chk("err_rd_pslverr", 32'(err[1]), 32'h1);
    chk("err_rd_prdata", 32'(rd[1]), 32'h0);
    xfer(0, 1'b1, 16'd5, 3'h1);
    xfer(1, 1'b0, 16'd0, 3'h0);
    #2;
    chk("no_alias_reg0", 32'(rd[1]), 32'h3);

    // new setup while in ACCESS restarts the transfer
    step();
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 16'd0; pwdata = 3'h1;
    step();
    penable = 1'b1;
    xfer(1, 1'b1, 16'd2, 3'h3);
    idle(1);

    // abort before the wait count expires
    step();
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 16'd3; pwdata = 3'h1;
    step();
    penable = 1'b1;
    step();
    psel = '0; penable = 1'b0;
    xfer(1, 1'b0, 16'd3, 3'h0);
    #2;
    chk("abort_reg3", 32'(rd[1]), 32'h6);

    // unselected bus activity
    repeat (20) begin
      step();
      psel    = '0;
      penable = 1'($urandom);
      pwrite  = 1'($urandom);
      paddr   = 16'($urandom);
      pwdata  = 3'($urandom);
    end

    // reset in the middle of a write to reg 2
    step();
    psel = 2'b10; penable = 1'b0; pwrite = 1'b1; paddr = 16'd2; pwdata = 3'h5;
    step();
    penable = 1'b1;
    #2;
    rst = 1'b1;
    clear_model();
    #1;
    chk("midrst_regs0", 32'(regs[0]), 32'h0);
    chk("midrst_regs1", 32'(regs[1]), 32'h0);
    chk("midrst_pready", 32'(rdy), 32'h0);
    step();
    psel = '0; penable = 1'b0;
    step();
    rst = 1'b0;
    idle(2);
    xfer(1, 1'b0, 16'd2, 3'h0);
    #2;
    chk("midrst_reg2", 32'(rd[1]), 32'h0);
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
